// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling UART receiver with configurable baud, parity, data and stop bits.
module uart_rx_os #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int OSR      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic [1:0] bd_rate,
    input  logic [1:0] par,
    input  logic       d_num,
    input  logic       s_num,
    output logic [7:0] dout,
    output logic [2:0] err,
    output logic       dout_valid
);
    localparam int DIV0 = CLK_FREQ / (1200 * OSR);
    localparam int DIV1 = CLK_FREQ / (2400 * OSR);
    localparam int DIV2 = CLK_FREQ / (4800 * OSR);
    localparam int DIV3 = CLK_FREQ / (9600 * OSR);
    localparam int W    = $clog2(DIV0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t      state_q, state_d;
    logic [1:0]  sync_q, sync_d;
    logic        prev_q, prev_d;
    logic [W-1:0] cnt_q, cnt_d, div_m1;
    logic [3:0]  tcnt_q, tcnt_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [7:0]  sh_q, sh_d;
    logic        pbit_q, pbit_d, nz_q, nz_d, ferr_q, ferr_d;
    logic [1:0]  bd_q, bd_d, par_q, par_d;
    logic        dn_q, dn_d, sn_q, sn_d;
    logic [7:0]  dout_q, dout_d, data;
    logic [2:0]  err_q, err_d;
    logic        valid_q, valid_d;
    logic        rxs, tick, smp, fin;

    assign rxs        = sync_q[1];
    assign dout       = dout_q;
    assign err        = err_q;
    assign dout_valid = valid_q;

    always_comb begin
        div_m1 = bd_q == 2'd0 ? W'(DIV0 - 1) :
                 bd_q == 2'd1 ? W'(DIV1 - 1) :
                 bd_q == 2'd2 ? W'(DIV2 - 1) : W'(DIV3 - 1);
        tick   = cnt_q == div_m1;
        smp    = tick && tcnt_q == (state_q == START ? 4'd7 : 4'd15);
        data   = dn_q ? sh_q : {1'b0, sh_q[7:1]};
        fin    = 1'b0;
        sync_d = {sync_q[0], rx};
        prev_d = rxs;
        state_d = state_q;
        cnt_d  = tick ? '0 : cnt_q + W'(1);
        tcnt_d = smp ? 4'd0 : tcnt_q + 4'(tick);
        bcnt_d = bcnt_q;
        sh_d   = sh_q;
        pbit_d = pbit_q;
        nz_d   = nz_q;
        ferr_d = ferr_q;
        bd_d   = bd_q;
        par_d  = par_q;
        dn_d   = dn_q;
        sn_d   = sn_q;
        dout_d = dout_q;
        err_d  = err_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: if (prev_q && !rxs) begin
                {bd_d, par_d, dn_d, sn_d} = {bd_rate, par, d_num, s_num};
                cnt_d   = '0;
                tcnt_d  = '0;
                bcnt_d  = '0;
                nz_d    = 1'b0;
                ferr_d  = 1'b0;
                state_d = START;
            end
            START: if (smp) state_d = rxs ? IDLE : DATA;
            DATA: if (smp) begin
                sh_d   = {rxs, sh_q[7:1]};
                nz_d   = nz_q | rxs;
                bcnt_d = bcnt_q + 3'd1;
                if (bcnt_q == {2'b11, dn_q}) state_d = ^par_q ? PARITY : STOP1;
            end
            PARITY: if (smp) begin
                pbit_d  = rxs;
                nz_d    = nz_q | rxs;
                state_d = STOP1;
            end
            STOP1: if (smp) begin
                ferr_d  = ferr_q | !rxs;
                nz_d    = nz_q | rxs;
                state_d = sn_q ? STOP2 : state_q;
                fin     = !sn_q;
            end
            STOP2: fin = smp;
            default: state_d = IDLE;
        endcase
        // finishing on the final stop sample lets a new start edge be caught half a bit later
        if (fin) begin
            dout_d  = data;
            err_d   = {!(nz_q | rxs), ferr_q | !rxs, ^par_q & (^data ^ pbit_q ^ par_q[0])};
            valid_d = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            pbit_q  <= 1'b0;
            nz_q    <= 1'b0;
            ferr_q  <= 1'b0;
            bd_q    <= '0;
            par_q   <= '0;
            dn_q    <= 1'b0;
            sn_q    <= 1'b0;
            dout_q  <= '0;
            err_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            pbit_q  <= pbit_d;
            nz_q    <= nz_d;
            ferr_q  <= ferr_d;
            bd_q    <= bd_d;
            par_q   <= par_d;
            dn_q    <= dn_d;
            sn_q    <= sn_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end
endmodule
